// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the six-register integer pipeline, with divider occupancy and pending-redirect tracking.
// Optional PIPE_CTRL_PERF_EN adds saturating stall-source cycle counters; otherwise those ports read 0.
module pipe_ctrl #(
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_stall_req,
  input  logic        id2_load_use_req,
  input  logic        exc_div_start,
  input  logic        exc_mispred,
  input  logic [31:0] exc_mispred_target,
  input  logic        dcache_stall_req,
  input  logic        mem_exception,
  input  logic [31:0] mem_exc_target,
  output logic [5:0]  stall,
  output logic [5:0]  flush,
  output logic        exception_flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        div_busy,
  output logic [31:0] perf_dcache_cyc,
  output logic [31:0] perf_div_cyc,
  output logic [31:0] perf_lu_cyc,
  output logic [31:0] perf_ic_cyc
);

  typedef enum logic {S_RUN, S_DIV} div_state_t;
  typedef enum logic {R_IDLE, R_PEND} redir_state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t   div_state;
  redir_state_t redir_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]  pend_target;
  logic         start_acc;
  logic         mis_acc;

  // Outputs are forced to 0 while reset is held, even with live inputs.
  always_comb begin
    stall           = '0;
    flush           = '0;
    exception_flush = 1'b0;
    pc_redirect     = 1'b0;
    redirect_target = '0;
    div_busy        = 1'b0;
    start_acc       = 1'b0;
    mis_acc         = 1'b0;
    if (rst) begin
      start_acc = (div_state == S_RUN) && exc_div_start && !dcache_stall_req;
      div_busy  = start_acc || (div_state == S_DIV);
      if (mem_exception) begin
        exception_flush = 1'b1;
      end else if (dcache_stall_req) begin
        stall = 6'b011111;
        flush = 6'b100000;
      end else if (div_busy) begin
        stall = 6'b001111;
        flush = 6'b010000;
      end else if (id2_load_use_req) begin
        stall = 6'b000111;
        flush = 6'b001000;
      end else if (icache_stall_req) begin
        stall = 6'b000001;
        flush = 6'b000010;
      end
      mis_acc = exc_mispred && !mem_exception && !stall[3];
      if (mis_acc) flush = flush | 6'b000110;
      if (mem_exception && !icache_stall_req) begin
        pc_redirect     = 1'b1;
        redirect_target = mem_exc_target;
      end else if (mis_acc && !icache_stall_req) begin
        pc_redirect     = 1'b1;
        redirect_target = exc_mispred_target;
      end else if (!mem_exception && !mis_acc && redir_state == R_PEND && !icache_stall_req) begin
        pc_redirect     = 1'b1;
        redirect_target = pend_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_state   <= S_RUN;
      cnt         <= '0;
      redir_state <= R_IDLE;
      pend_target <= '0;
    end else begin
      if (mem_exception) begin
        div_state <= S_RUN;
        cnt       <= '0;
      end else begin
        case (div_state)
          S_RUN: if (start_acc) begin
            cnt       <= CNT_LOAD;
            div_state <= S_DIV;
          end
          S_DIV: begin
            if (cnt <= CNT_ONE) begin
              cnt       <= '0;
              div_state <= S_RUN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: div_state <= S_RUN;
        endcase
      end

      // A newly accepted redirect replaces whatever was pending.
      if (mem_exception) begin
        if (icache_stall_req) begin
          redir_state <= R_PEND;
          pend_target <= mem_exc_target;
        end else begin
          redir_state <= R_IDLE;
        end
      end else if (mis_acc) begin
        if (icache_stall_req) begin
          redir_state <= R_PEND;
          pend_target <= exc_mispred_target;
        end else begin
          redir_state <= R_IDLE;
        end
      end else if (redir_state == R_PEND && !icache_stall_req) begin
        redir_state <= R_IDLE;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic win_dc, win_div, win_lu, win_ic;

  assign win_dc  = rst && !mem_exception && dcache_stall_req;
  assign win_div = rst && !mem_exception && !dcache_stall_req && div_busy;
  assign win_lu  = rst && !mem_exception && !dcache_stall_req && !div_busy && id2_load_use_req;
  assign win_ic  = rst && !mem_exception && !dcache_stall_req && !div_busy && !id2_load_use_req
                   && icache_stall_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_dcache_cyc <= '0;
      perf_div_cyc    <= '0;
      perf_lu_cyc     <= '0;
      perf_ic_cyc     <= '0;
    end else begin
      if (win_dc  && perf_dcache_cyc != '1) perf_dcache_cyc <= perf_dcache_cyc + 1'b1;
      if (win_div && perf_div_cyc    != '1) perf_div_cyc    <= perf_div_cyc + 1'b1;
      if (win_lu  && perf_lu_cyc     != '1) perf_lu_cyc     <= perf_lu_cyc + 1'b1;
      if (win_ic  && perf_ic_cyc     != '1) perf_ic_cyc     <= perf_ic_cyc + 1'b1;
    end
  end
`else
  assign perf_dcache_cyc = '0;
  assign perf_div_cyc    = '0;
  assign perf_lu_cyc     = '0;
  assign perf_ic_cyc     = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icache_stall_req = 1'b0;
  logic        id2_load_use_req = 1'b0;
  logic        exc_div_start = 1'b0;
  logic        exc_mispred = 1'b0;
  logic [31:0] exc_mispred_target = '0;
  logic        dcache_stall_req = 1'b0;
  logic        mem_exception = 1'b0;
  logic [31:0] mem_exc_target = '0;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic        exception_flush;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        div_busy;
  logic [31:0] perf_dcache_cyc, perf_div_cyc, perf_lu_cyc, perf_ic_cyc;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_ctrl #(.DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .icache_stall_req(icache_stall_req), .id2_load_use_req(id2_load_use_req),
    .exc_div_start(exc_div_start), .exc_mispred(exc_mispred),
    .exc_mispred_target(exc_mispred_target), .dcache_stall_req(dcache_stall_req),
    .mem_exception(mem_exception), .mem_exc_target(mem_exc_target),
    .stall(stall), .flush(flush), .exception_flush(exception_flush),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target), .div_busy(div_busy),
    .perf_dcache_cyc(perf_dcache_cyc), .perf_div_cyc(perf_div_cyc),
    .perf_lu_cyc(perf_lu_cyc), .perf_ic_cyc(perf_ic_cyc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [46:0] got;
    icache_stall_req = 1'b1;
    id2_load_use_req = 1'b1;
    exc_mispred = 1'b1;
    exc_mispred_target = 32'h1234_5678;
    repeat (2) @(negedge clk);
    got = {stall, flush, exception_flush, pc_redirect, redirect_target, div_busy};
    total_cnt++;
    if (got !== 47'd0) $display("FAIL reset_outputs: got %h expected 0", got);
    else pass_cnt++;
    total_cnt++;
    if ({perf_dcache_cyc, perf_div_cyc, perf_lu_cyc, perf_ic_cyc} !== 128'd0)
      $display("FAIL reset_perf: got %h expected 0",
               {perf_dcache_cyc, perf_div_cyc, perf_lu_cyc, perf_ic_cyc});
    else pass_cnt++;
    icache_stall_req = 1'b0;
    id2_load_use_req = 1'b0;
    exc_mispred = 1'b0;
    exc_mispred_target = '0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_div();
    logic [12:0] exp;
    logic [12:0] got;
    tick();
    exc_div_start = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      exp = (k <= 32) ? {6'b001111, 6'b010000, 1'b1} : 13'd0;
      got = {stall, flush, div_busy};
      total_cnt++;
      if (got !== exp) $display("FAIL div_hold cyc%0d: got %b expected %b", k, got, exp);
      else pass_cnt++;
      tick();
      exc_div_start = (k == 9);
    end
    exc_div_start = 1'b0;
  endtask

  task automatic test_load_use_icache();
    tick();
    id2_load_use_req = 1'b1;
    icache_stall_req = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({stall, flush} !== {6'b000111, 6'b001000})
      $display("FAIL lu_over_ic: got %b expected %b", {stall, flush}, {6'b000111, 6'b001000});
    else pass_cnt++;
    tick();
    dcache_stall_req = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({stall, flush} !== {6'b011111, 6'b100000})
      $display("FAIL dc_over_lu: got %b expected %b", {stall, flush}, {6'b011111, 6'b100000});
    else pass_cnt++;
    tick();
    dcache_stall_req = 1'b0;
    id2_load_use_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({stall, flush} !== {6'b000001, 6'b000010})
      $display("FAIL ic_only: got %b expected %b", {stall, flush}, {6'b000001, 6'b000010});
    else pass_cnt++;
    tick();
    icache_stall_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({stall, flush, pc_redirect} !== 13'd0)
      $display("FAIL no_source: got %b expected 0", {stall, flush, pc_redirect});
    else pass_cnt++;
  endtask

  task automatic test_mispred_dcache();
    tick();
    dcache_stall_req = 1'b1;
    exc_mispred = 1'b1;
    exc_mispred_target = 32'h8000_1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({pc_redirect, stall, flush} !== {1'b0, 6'b011111, 6'b100000})
        $display("FAIL mis_blocked cyc%0d: got %b expected %b", k,
                 {pc_redirect, stall, flush}, {1'b0, 6'b011111, 6'b100000});
      else pass_cnt++;
      tick();
    end
    dcache_stall_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({pc_redirect, redirect_target, stall, flush} !== {1'b1, 32'h8000_1000, 6'b0, 6'b000110})
      $display("FAIL mis_accept: got %h expected %h", {pc_redirect, redirect_target, stall, flush},
               {1'b1, 32'h8000_1000, 6'b0, 6'b000110});
    else pass_cnt++;
    tick();
    exc_mispred = 1'b0;
    exc_mispred_target = '0;
    @(negedge clk);
    total_cnt++;
    if (pc_redirect !== 1'b0) $display("FAIL mis_single: got %b expected 0", pc_redirect);
    else pass_cnt++;
  endtask

  task automatic test_pend();
    tick();
    icache_stall_req = 1'b1;
    exc_mispred = 1'b1;
    exc_mispred_target = 32'h8000_2000;
    @(negedge clk);
    total_cnt++;
    if ({pc_redirect, stall, flush} !== {1'b0, 6'b000001, 6'b000110})
      $display("FAIL pend_accept: got %b expected %b", {pc_redirect, stall, flush},
               {1'b0, 6'b000001, 6'b000110});
    else pass_cnt++;
    tick();
    exc_mispred = 1'b0;
    exc_mispred_target = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if (pc_redirect !== 1'b0) $display("FAIL pend_hold cyc%0d: got %b expected 0", k, pc_redirect);
      else pass_cnt++;
      tick();
    end
    icache_stall_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({pc_redirect, redirect_target} !== {1'b1, 32'h8000_2000})
      $display("FAIL pend_fire: got %h expected %h", {pc_redirect, redirect_target},
               {1'b1, 32'h8000_2000});
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (pc_redirect !== 1'b0) $display("FAIL pend_single: got %b expected 0", pc_redirect);
    else pass_cnt++;
  endtask

  task automatic test_exc_div();
    tick();
    exc_div_start = 1'b1;
    tick();
    exc_div_start = 1'b0;
    repeat (22) tick();
    // cycle 23 after start: counter holds 10
    mem_exception = 1'b1;
    mem_exc_target = 32'hBFC0_0380;
    dcache_stall_req = 1'b1;
    exc_mispred = 1'b1;
    exc_mispred_target = 32'h1111_0000;
    @(negedge clk);
    total_cnt++;
    if ({exception_flush, pc_redirect, redirect_target, stall, flush} !==
        {1'b1, 1'b1, 32'hBFC0_0380, 6'b0, 6'b0})
      $display("FAIL exc_in_div: got %h expected %h",
               {exception_flush, pc_redirect, redirect_target, stall, flush},
               {1'b1, 1'b1, 32'hBFC0_0380, 6'b0, 6'b0});
    else pass_cnt++;
    tick();
    mem_exception = 1'b0;
    mem_exc_target = '0;
    dcache_stall_req = 1'b0;
    exc_mispred = 1'b0;
    exc_mispred_target = '0;
    @(negedge clk);
    total_cnt++;
    if ({div_busy, stall, pc_redirect, exception_flush} !== 9'd0)
      $display("FAIL exc_div_after: got %b expected 0", {div_busy, stall, pc_redirect, exception_flush});
    else pass_cnt++;
  endtask

  task automatic test_exc_pend();
    tick();
    icache_stall_req = 1'b1;
    exc_mispred = 1'b1;
    exc_mispred_target = 32'h8000_3000;
    tick();
    exc_mispred = 1'b0;
    exc_mispred_target = '0;
    mem_exception = 1'b1;
    mem_exc_target = 32'hBFC0_0200;
    @(negedge clk);
    total_cnt++;
    if ({exception_flush, pc_redirect, stall, flush} !== {1'b1, 1'b0, 6'b0, 6'b0})
      $display("FAIL exc_pend_cyc: got %b expected %b", {exception_flush, pc_redirect, stall, flush},
               {1'b1, 1'b0, 6'b0, 6'b0});
    else pass_cnt++;
    tick();
    mem_exception = 1'b0;
    mem_exc_target = '0;
    tick();
    icache_stall_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({pc_redirect, redirect_target} !== {1'b1, 32'hBFC0_0200})
      $display("FAIL exc_pend_fire: got %h expected %h", {pc_redirect, redirect_target},
               {1'b1, 32'hBFC0_0200});
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (pc_redirect !== 1'b0) $display("FAIL exc_pend_single: got %b expected 0", pc_redirect);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    logic [46:0] got;
    tick();
    exc_div_start = 1'b1;
    tick();
    exc_div_start = 1'b0;
    repeat (5) tick();
    id2_load_use_req = 1'b1;
    rst = 1'b0;
    #1;
    got = {stall, flush, exception_flush, pc_redirect, redirect_target, div_busy};
    total_cnt++;
    if (got !== 47'd0) $display("FAIL rst_mid_div: got %h expected 0", got);
    else pass_cnt++;
    id2_load_use_req = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({div_busy, stall} !== 7'd0) $display("FAIL rst_div_after: got %b expected 0", {div_busy, stall});
    else pass_cnt++;
    tick();
    icache_stall_req = 1'b1;
    exc_mispred = 1'b1;
    exc_mispred_target = 32'h8000_4000;
    tick();
    exc_mispred = 1'b0;
    exc_mispred_target = '0;
    tick();
    rst = 1'b0;
    #1;
    got = {stall, flush, exception_flush, pc_redirect, redirect_target, div_busy};
    total_cnt++;
    if (got !== 47'd0) $display("FAIL rst_mid_pend: got %h expected 0", got);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    icache_stall_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (pc_redirect !== 1'b0) $display("FAIL rst_stale_redir cyc%0d: got %b expected 0", k, pc_redirect);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_load_use_icache();
    test_mispred_dcache();
    test_pend();
    test_exc_div();
    test_exc_pend();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush scheduler for the six-register integer pipeline: pc, if_id1, id1_id2, id2_exc, exc_mem, mem_wb. It collects stall requests from IF, ID2, EXC and MEM, and redirect requests from the EXC branch unit and the MEM exception unit. It drives per-register stall/flush vectors, the global exception_flush, and a single PC redirect port. It also owns the multi-cycle divider occupancy counter and a pending-redirect latch for redirects that arrive during an I-cache miss.

Parameters:
DIV_LAT, 33, cycles the EXC stage is held for one divide, start cycle included (range 2..63)
CNT_W, 6, divider counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
icache_stall_req  in  1  IF miss in progress
id2_load_use_req  in  1  ID2 depends on a load currently in EXC
exc_div_start  in  1  one-cycle pulse: divide entered EXC
exc_mispred  in  1  EXC branch mispredicted; held while the branch sits in EXC
exc_mispred_target  in  32  correct PC
dcache_stall_req  in  1  MEM miss in progress
mem_exception  in  1  exception/eret/refetch committed in MEM
mem_exc_target  in  32  vector, EPC or refetch PC
stall  out  6  bit0 pc, bit1 if_id1, bit2 id1_id2, bit3 id2_exc, bit4 exc_mem, bit5 mem_wb
flush  out  6  same bit order; bubble insert (register acts only when flush & !stall)
exception_flush  out  1  clears all stage registers
pc_redirect  out  1  PC loads redirect_target this cycle
redirect_target  out  32  redirect PC
div_busy  out  1  divide occupying EXC

Behaviour:
- rst low, taking effect immediately: div FSM to RUN, cnt to 0, redirect FSM to IDLE, latched target to 0. All outputs read 0.
- Outputs are combinational from state plus inputs. State updates on posedge clk.
- Div FSM has two states, RUN and DIV.
  - RUN: an exc_div_start with dcache_stall_req=0 loads cnt=DIV_LAT-1 and moves to DIV.
  - DIV: cnt decrements every cycle, regardless of other stalls. When cnt goes 1 to 0, return to RUN.
  - exc_div_start is ignored while in DIV.
  - div_busy = (RUN & accepted start) | DIV. The EXC stage is therefore held for exactly DIV_LAT cycles.
- Stall sources, oldest wins and only one applies per cycle:
  - dcache_stall_req: stall=6'b011111, flush=6'b100000.
  - div_busy: stall=6'b001111, flush=6'b010000.
  - id2_load_use_req: stall=6'b000111, flush=6'b001000.
  - icache_stall_req: stall=6'b000001, flush=6'b000010.
  - No source active: stall=0, flush=0.
- Mispredict is accepted when exc_mispred=1 and stall[3]=0.
  - The delay slot is in ID2 at that point and is kept.
  - flush |= 6'b000110.
  - If icache_stall_req=0: pc_redirect=1, redirect_target=exc_mispred_target in the same cycle.
  - Otherwise: latch the target and go to PEND.
- Redirect FSM has two states, IDLE and PEND.
  - PEND: pc_redirect=0 while icache_stall_req=1.
  - On the first cycle with icache_stall_req=0: pc_redirect=1 with the latched target, then IDLE.
  - Input target changes while in PEND are ignored.
- mem_exception has the highest priority and is never blocked, including by dcache_stall_req.
  - Same cycle: exception_flush=1, stall=0, flush=0.
  - Div FSM forced to RUN and cnt=0; the divider result is discarded.
  - Any pending mispredict redirect is dropped.
  - Redirect to mem_exc_target is immediate when icache_stall_req=0, otherwise it goes to PEND with mem_exc_target latched.
  - An exception arriving while already in PEND overwrites the latched target.
- Simultaneous exc_mispred and mem_exception: the exception wins and the mispredict is ignored.
- pc_redirect is asserted for at most one cycle per accepted redirect.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: four 32-bit saturating counters, perf_dcache_cyc, perf_div_cyc, perf_lu_cyc, perf_ic_cyc.
  - Each counts cycles in which its source is the winning stall source.
  - Cleared by rst.
  - Exposed as output ports.
- Undefined: the ports still exist and are tied to 0, with no counter logic.

Test Plan:
1. DIV_LAT=33, exc_div_start pulse at cycle 0 -> stall=6'b001111 and flush=6'b010000 for cycles 0..32; cycle 33 stall=0, div_busy=0.
2. id2_load_use_req=1 and icache_stall_req=1 together -> stall=6'b000111, flush=6'b001000; after load-use drops, stall=6'b000001, flush=6'b000010.
3. dcache_stall_req=1 for 5 cycles with exc_mispred=1, target 0x80001000 -> pc_redirect=0 throughout; first cycle after dcache drops: pc_redirect=1, target 0x80001000, flush=6'b000110.
4. exc_mispred accepted (target 0x80002000) with icache_stall_req=1 for 4 cycles, target input changed to 0x0 meanwhile -> single pc_redirect with 0x80002000 on the cycle icache drops.
5. mem_exception (target 0xBFC00380) at cnt=10 in DIV -> same cycle exception_flush=1, pc_redirect=1, target 0xBFC00380, stall=0; next cycle div_busy=0.
6. rst pulled low mid-DIV and in PEND -> all outputs 0 immediately; after release, no stale redirect and div_busy=0.
